// File: rtl/mem_stage.sv
// Memory pipeline stage: posted store buffer drained to memory, single
// outstanding blocking load with byte/half/word extraction and sign extension.
module mem_stage #(
    parameter int ADDR_W     = 32,
    parameter int WBUF_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              err,
    output logic              busy,
    output logic              mem_valid,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);
    localparam int PTR_W = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(WBUF_DEPTH);
    localparam logic [PTR_W:0] ZERO_CNT = {(PTR_W+1){1'b0}};
    localparam logic [PTR_W-1:0] ONE_PTR = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [PTR_W:0] ONE_CNT = {{PTR_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LD_REQ  = 2'd1,
        S_LD_WAIT = 2'd2,
        S_RESP    = 2'd3
    } state_t;

    function automatic logic [3:0] be_of(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   be_of = 4'b0001 << off;
            2'b01:   be_of = 4'b0011 << off;
            default: be_of = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] d);
        case (size)
            2'b00:   replicate = {4{d[7:0]}};
            2'b01:   replicate = {2{d[15:0]}};
            default: replicate = d;
        endcase
    endfunction

    // Word loads are always aligned, so the lane shift is zero and the word passes through.
    function automatic logic [31:0] extract(input logic [31:0] d, input logic [1:0] off,
                                            input logic [1:0] size, input logic sgn);
        logic [31:0] sh;
        sh = d >> {off, 3'b000};
        case (size)
            2'b00:   extract = {{24{sgn & sh[7]}}, sh[7:0]};
            2'b01:   extract = {{16{sgn & sh[15]}}, sh[15:0]};
            default: extract = sh;
        endcase
    endfunction

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic [ADDR_W-1:0] buf_addr_q [WBUF_DEPTH];
    logic [ADDR_W-1:0] buf_addr_d [WBUF_DEPTH];
    logic [31:0]       buf_data_q [WBUF_DEPTH];
    logic [31:0]       buf_data_d [WBUF_DEPTH];
    logic [3:0]        buf_be_q   [WBUF_DEPTH];
    logic [3:0]        buf_be_d   [WBUF_DEPTH];
    logic [ADDR_W-1:0] ld_addr_q, ld_addr_d;
    logic [1:0]        ld_off_q, ld_off_d, ld_size_q, ld_size_d;
    logic              ld_signed_q, ld_signed_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              err_q, err_d;

    logic bad_s, full_s, empty_s, drain_s, accept_s, push_s, pop_s, ld_start_s;

    // Request acceptance, buffer status and handshake decode.
    always_comb begin
        bad_s      = (req_size == 2'b11) || ((req_size == 2'b01) && req_addr[0])
                     || ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
        full_s     = (count_q == FULL_CNT);
        empty_s    = (count_q == ZERO_CNT);
        drain_s    = (state_q == S_IDLE) && !empty_s;
        if (bad_s) begin
            req_ready = 1'b1;
        end else if (req_write) begin
            req_ready = !full_s;
        end else begin
            req_ready = (state_q == S_IDLE) && empty_s;
        end
        accept_s   = req_valid && req_ready;
        push_s     = accept_s && req_write && !bad_s;
        ld_start_s = accept_s && !req_write && !bad_s;
        pop_s      = drain_s && mem_ready;
    end

    // Next-state for the load FSM, store buffer and response/error registers.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        buf_addr_d  = buf_addr_q;
        buf_data_d  = buf_data_q;
        buf_be_d    = buf_be_q;
        ld_addr_d   = ld_addr_q;
        ld_off_d    = ld_off_q;
        ld_size_d   = ld_size_q;
        ld_signed_d = ld_signed_q;
        rsp_rdata_d = rsp_rdata_q;
        err_d       = accept_s && bad_s;

        case (state_q)
            S_IDLE:    if (ld_start_s) state_d = S_LD_REQ; else state_d = S_IDLE;
            S_LD_REQ:  if (mem_ready)  state_d = S_LD_WAIT; else state_d = S_LD_REQ;
            S_LD_WAIT: if (mem_rvalid) state_d = S_RESP; else state_d = S_LD_WAIT;
            S_RESP:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase

        if (ld_start_s) begin
            ld_addr_d   = {req_addr[ADDR_W-1:2], 2'b00};
            ld_off_d    = req_addr[1:0];
            ld_size_d   = req_size;
            ld_signed_d = req_signed;
        end else begin
            ld_addr_d   = ld_addr_q;
        end

        if ((state_q == S_LD_WAIT) && mem_rvalid) begin
            rsp_rdata_d = extract(mem_rdata, ld_off_q, ld_size_q, ld_signed_q);
        end else begin
            rsp_rdata_d = rsp_rdata_q;
        end

        if (push_s) begin
            buf_addr_d[wr_ptr_q] = {req_addr[ADDR_W-1:2], 2'b00};
            buf_data_d[wr_ptr_q] = replicate(req_size, req_wdata);
            buf_be_d[wr_ptr_q]   = be_of(req_size, req_addr[1:0]);
            wr_ptr_d             = wr_ptr_q + ONE_PTR;
        end else begin
            wr_ptr_d             = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + ONE_PTR;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + ONE_CNT;
            2'b01:   count_d = count_q - ONE_CNT;
            default: count_d = count_q;
        endcase
    end

    // Memory request mux: store drain and load request are mutually exclusive by FSM state.
    always_comb begin
        mem_valid = 1'b0;
        mem_write = 1'b0;
        mem_addr  = {ADDR_W{1'b0}};
        mem_wdata = 32'h0000_0000;
        mem_be    = 4'b0000;
        if (drain_s) begin
            mem_valid = 1'b1;
            mem_write = 1'b1;
            mem_addr  = buf_addr_q[rd_ptr_q];
            mem_wdata = buf_data_q[rd_ptr_q];
            mem_be    = buf_be_q[rd_ptr_q];
        end else if (state_q == S_LD_REQ) begin
            mem_valid = 1'b1;
            mem_addr  = ld_addr_q;
            mem_be    = be_of(ld_size_q, ld_off_q);
        end else begin
            mem_valid = 1'b0;
        end
    end

    assign rsp_valid = (state_q == S_RESP);
    assign rsp_rdata = rsp_rdata_q;
    assign err       = err_q;
    assign busy      = !empty_s || (state_q != S_IDLE);

    // State registers; reset discards buffered stores and any outstanding load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= {PTR_W{1'b0}};
            rd_ptr_q    <= {PTR_W{1'b0}};
            count_q     <= ZERO_CNT;
            ld_addr_q   <= {ADDR_W{1'b0}};
            ld_off_q    <= 2'b00;
            ld_size_q   <= 2'b00;
            ld_signed_q <= 1'b0;
            rsp_rdata_q <= 32'h0000_0000;
            err_q       <= 1'b0;
            for (int i = 0; i < WBUF_DEPTH; i++) begin
                buf_addr_q[i] <= {ADDR_W{1'b0}};
                buf_data_q[i] <= 32'h0000_0000;
                buf_be_q[i]   <= 4'b0000;
            end
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ld_addr_q   <= ld_addr_d;
            ld_off_q    <= ld_off_d;
            ld_size_q   <= ld_size_d;
            ld_signed_q <= ld_signed_d;
            rsp_rdata_q <= rsp_rdata_d;
            err_q       <= err_d;
            buf_addr_q  <= buf_addr_d;
            buf_data_q  <= buf_data_d;
            buf_be_q    <= buf_be_d;
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage: stores, loads, ordering, errors and reset.
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_write, req_signed, req_ready;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, err, busy;
    logic [31:0] rsp_rdata;
    logic        mem_valid, mem_write, mem_ready, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    int checks = 0;
    int passed = 0;

    mem_stage #(.ADDR_W(32), .WBUF_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_write(req_write), .req_size(req_size),
        .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .err(err), .busy(busy),
        .mem_valid(mem_valid), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ready(mem_ready),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] d);
        req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = d;
    endtask

    task automatic test_reset;
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b10;
        req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        #1 rst = 1'b0;
        #3;
        checks++; if (mem_valid !== 1'b0) $display("FAIL rst_mem_valid: got %b want 0", mem_valid); else passed++;
        checks++; if (rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); else passed++;
        checks++; if (err !== 1'b0) $display("FAIL rst_err: got %b want 0", err); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else passed++;
        checks++; if (rsp_rdata !== 32'h0) $display("FAIL rst_rdata: got %h want 0", rsp_rdata); else passed++;
        tick;
        tick;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b1) $display("FAIL rst_first_ready: got %b want 1", req_ready); else passed++;
        tick;
    endtask

    task automatic test_store_byte;
        mem_ready = 1'b1;
        drive(1'b1, 2'b00, 1'b0, 32'h0000_1003, 32'h0000_00A5);
        #1;
        checks++; if (req_ready !== 1'b1) $display("FAIL sb_ready: got %b want 1", req_ready); else passed++;
        tick;
        req_valid = 1'b0;
        checks++; if (mem_valid !== 1'b1) $display("FAIL sb_mem_valid: got %b want 1", mem_valid); else passed++;
        checks++; if (mem_write !== 1'b1) $display("FAIL sb_mem_write: got %b want 1", mem_write); else passed++;
        checks++; if (mem_addr !== 32'h0000_1000) $display("FAIL sb_addr: got %h want 00001000", mem_addr); else passed++;
        checks++; if (mem_be !== 4'b1000) $display("FAIL sb_be: got %b want 1000", mem_be); else passed++;
        checks++; if (mem_wdata !== 32'hA5A5_A5A5) $display("FAIL sb_wdata: got %h want a5a5a5a5", mem_wdata); else passed++;
        tick;
        checks++; if (mem_valid !== 1'b0 || busy !== 1'b0) $display("FAIL sb_drained: got valid=%b busy=%b want 0 0", mem_valid, busy); else passed++;
        // half store at offset 2: be 1100, data replicated in both halves
        drive(1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h0000_BEEF);
        tick;
        req_valid = 1'b0;
        checks++; if (mem_be !== 4'b1100 || mem_wdata !== 32'hBEEF_BEEF || mem_addr !== 32'h0000_2000)
            $display("FAIL sh_lanes: got be=%b data=%h addr=%h want 1100 beefbeef 00002000", mem_be, mem_wdata, mem_addr); else passed++;
        tick;
    endtask

    task automatic test_store_fill;
        logic [31:0] exp_d;
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'b10, 1'b0, 32'h100 + 32'(4 * i), 32'h1111_1111 * 32'(i + 1));
            #1;
            checks++; if (req_ready !== 1'b1) $display("FAIL fill_ready%0d: got %b want 1", i, req_ready); else passed++;
            tick;
        end
        drive(1'b1, 2'b10, 1'b0, 32'h110, 32'h5555_5555);
        #1;
        checks++; if (req_ready !== 1'b0) $display("FAIL fill_full: got %b want 0", req_ready); else passed++;
        checks++; if (mem_valid !== 1'b1 || mem_addr !== 32'h100) $display("FAIL fill_head: got v=%b a=%h want 1 100", mem_valid, mem_addr); else passed++;
        tick;
        checks++; if (mem_addr !== 32'h100 || mem_wdata !== 32'h1111_1111) $display("FAIL fill_stable: got a=%h d=%h want 100 11111111", mem_addr, mem_wdata); else passed++;
        mem_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b0) $display("FAIL fill_nobypass: got %b want 0", req_ready); else passed++;
        tick;
        mem_ready = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) $display("FAIL fill_after_pop: got %b want 1", req_ready); else passed++;
        tick;
        req_valid = 1'b0;
        mem_ready = 1'b1;
        for (int k = 1; k < 5; k++) begin
            exp_d = 32'h1111_1111 * 32'(k + 1);
            checks++; if (mem_valid !== 1'b1 || mem_addr !== 32'h100 + 32'(4 * k) || mem_wdata !== exp_d)
                $display("FAIL fill_order%0d: got v=%b a=%h d=%h want 1 %h %h", k, mem_valid, mem_addr, mem_wdata, 32'h100 + 32'(4 * k), exp_d); else passed++;
            tick;
        end
        checks++; if (mem_valid !== 1'b0 || busy !== 1'b0) $display("FAIL fill_empty: got v=%b busy=%b want 0 0", mem_valid, busy); else passed++;
    endtask

    task automatic do_load(input string nm, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                           input logic [31:0] rd, input logic [3:0] exp_be, input logic [31:0] exp_d);
        mem_ready = 1'b1;
        drive(1'b0, sz, sg, a, 32'h0);
        #1;
        checks++; if (req_ready !== 1'b1) $display("FAIL %s_ready: got %b want 1", nm, req_ready); else passed++;
        tick;
        req_valid = 1'b0;
        checks++; if (mem_valid !== 1'b1 || mem_write !== 1'b0 || mem_be !== exp_be || mem_addr !== (a & 32'hFFFF_FFFC))
            $display("FAIL %s_req: got v=%b w=%b be=%b a=%h want 1 0 %b %h", nm, mem_valid, mem_write, mem_be, mem_addr, exp_be, a & 32'hFFFF_FFFC); else passed++;
        tick;
        mem_rvalid = 1'b1; mem_rdata = rd;
        #1;
        checks++; if (rsp_valid !== 1'b0 || mem_valid !== 1'b0) $display("FAIL %s_wait: got rsp=%b mv=%b want 0 0", nm, rsp_valid, mem_valid); else passed++;
        tick;
        mem_rvalid = 1'b0;
        checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== exp_d) $display("FAIL %s_rsp: got v=%b d=%h want 1 %h", nm, rsp_valid, rsp_rdata, exp_d); else passed++;
        tick;
        checks++; if (rsp_valid !== 1'b0 || rsp_rdata !== exp_d || busy !== 1'b0) $display("FAIL %s_hold: got v=%b d=%h busy=%b want 0 %h 0", nm, rsp_valid, rsp_rdata, busy, exp_d); else passed++;
    endtask

    task automatic test_loads;
        do_load("lh_signed",   2'b01, 1'b1, 32'h2002, 32'h8001_0000, 4'b1100, 32'hFFFF_8001);
        do_load("lh_unsigned", 2'b01, 1'b0, 32'h2002, 32'h8001_0000, 4'b1100, 32'h0000_8001);
        do_load("lb_unsigned", 2'b00, 1'b0, 32'h2001, 32'h1234_5678, 4'b0010, 32'h0000_0056);
        do_load("lb_signed",   2'b00, 1'b1, 32'h2003, 32'h8034_5678, 4'b1000, 32'hFFFF_FF80);
        do_load("lw",          2'b10, 1'b1, 32'h3000, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);
    endtask

    task automatic test_back_to_back_order;
        mem_ready = 1'b0;
        drive(1'b1, 2'b10, 1'b0, 32'h400, 32'h0404_0404);
        tick;
        drive(1'b0, 2'b10, 1'b0, 32'h500, 32'h0);
        #1;
        checks++; if (req_ready !== 1'b0) $display("FAIL ord_blocked: got %b want 0", req_ready); else passed++;
        checks++; if (mem_valid !== 1'b1 || mem_write !== 1'b1) $display("FAIL ord_store_first: got v=%b w=%b want 1 1", mem_valid, mem_write); else passed++;
        mem_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b0) $display("FAIL ord_hs_pending: got %b want 0", req_ready); else passed++;
        tick;
        checks++; if (req_ready !== 1'b1 || mem_valid !== 1'b0) $display("FAIL ord_after_pop: got r=%b v=%b want 1 0", req_ready, mem_valid); else passed++;
        tick;
        req_valid = 1'b0;
        checks++; if (mem_valid !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 32'h500) $display("FAIL ord_load_req: got v=%b w=%b a=%h want 1 0 500", mem_valid, mem_write, mem_addr); else passed++;
        tick;
        mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
        tick;
        mem_rvalid = 1'b0;
        checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hCAFE_F00D) $display("FAIL ord_rsp: got v=%b d=%h want 1 cafef00d", rsp_valid, rsp_rdata); else passed++;
        tick;
    endtask

    task automatic test_err;
        logic seen;
        mem_ready = 1'b0;
        drive(1'b0, 2'b10, 1'b0, 32'h3001, 32'h0);
        #1;
        checks++; if (req_ready !== 1'b1) $display("FAIL err_lw_ready: got %b want 1", req_ready); else passed++;
        tick;
        req_valid = 1'b0;
        checks++; if (err !== 1'b1 || mem_valid !== 1'b0 || busy !== 1'b0) $display("FAIL err_lw: got err=%b v=%b busy=%b want 1 0 0", err, mem_valid, busy); else passed++;
        mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick;
            if (rsp_valid !== 1'b0 || mem_valid !== 1'b0) seen = 1'b1;
        end
        mem_rvalid = 1'b0; mem_ready = 1'b0;
        checks++; if (seen !== 1'b0 || err !== 1'b0) $display("FAIL err_lw_quiet: got activity=%b err=%b want 0 0", seen, err); else passed++;
        drive(1'b1, 2'b11, 1'b0, 32'h800, 32'h1234_5678);
        tick;
        req_valid = 1'b0;
        checks++; if (err !== 1'b1 || mem_valid !== 1'b0 || busy !== 1'b0) $display("FAIL err_sz11: got err=%b v=%b busy=%b want 1 0 0", err, mem_valid, busy); else passed++;
        drive(1'b1, 2'b01, 1'b0, 32'h1001, 32'h1234_5678);
        tick;
        req_valid = 1'b0;
        checks++; if (err !== 1'b1 || busy !== 1'b0) $display("FAIL err_sh_misal: got err=%b busy=%b want 1 0", err, busy); else passed++;
        tick;
        checks++; if (err !== 1'b0) $display("FAIL err_pulse: got %b want 0", err); else passed++;
    endtask

    task automatic test_reset_mid;
        logic seen;
        mem_ready = 1'b1;
        drive(1'b0, 2'b10, 1'b0, 32'h600, 32'h0);
        tick;
        drive(1'b1, 2'b10, 1'b0, 32'h700, 32'h0000_0077);
        tick;
        drive(1'b1, 2'b10, 1'b0, 32'h704, 32'h0000_0078);
        tick;
        req_valid = 1'b0; req_write = 1'b0; mem_ready = 1'b0;
        checks++; if (busy !== 1'b1 || mem_valid !== 1'b0) $display("FAIL rm_pre: got busy=%b v=%b want 1 0", busy, mem_valid); else passed++;
        #2 rst = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || mem_valid !== 1'b0 || rsp_valid !== 1'b0 || err !== 1'b0 || rsp_rdata !== 32'h0)
            $display("FAIL rm_cleared: got busy=%b v=%b rsp=%b err=%b d=%h want 0 0 0 0 0", busy, mem_valid, rsp_valid, err, rsp_rdata); else passed++;
        @(negedge clk);
        rst = 1'b1;
        mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            if (rsp_valid !== 1'b0 || mem_valid !== 1'b0) seen = 1'b1;
        end
        mem_rvalid = 1'b0;
        checks++; if (seen !== 1'b0) $display("FAIL rm_late_rvalid: got activity=%b want 0", seen); else passed++;
        checks++; if (req_ready !== 1'b1 || busy !== 1'b0) $display("FAIL rm_ready: got r=%b busy=%b want 1 0", req_ready, busy); else passed++;
    endtask

    initial begin
        test_reset;
        test_store_byte;
        test_store_fill;
        test_loads;
        test_back_to_back_order;
        test_err;
        test_reset_mid;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
